// File: rtl/count_wrap_monitor.sv
// Watches a 4-bit counter stream, tags step/wrap/jump/match transitions and
// queues them in a show-ahead FIFO. Define COUNT_WRAP_MONITOR_STATS_EN for wrap counters.
module count_wrap_monitor #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       count_in,
  input  logic             count_valid,
  input  logic             match_en,
  input  logic [3:0]       match_value,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_data,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] wrap_up_cnt,
  output logic [CNT_W-1:0] wrap_dn_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]  prev;
  logic        prev_valid;
  logic [3:0]  d;
  logic        wrap_up, wrap_dn, jump, match;
  logic        push, pop, full, empty, drop;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  mem [DEPTH];

  // Transition classification against the previous accepted sample.
  always_comb begin
    d       = count_in - prev;
    wrap_up = prev_valid && (d == 4'd1) && (prev == 4'd15);
    wrap_dn = prev_valid && (d == 4'd15) && (prev == 4'd0);
    jump    = prev_valid && (d != 4'd0) && (d != 4'd1) && (d != 4'd15);
    match   = match_en && (count_in == match_value) &&
              (!prev_valid || (prev != match_value));
  end

  // Handshake: the head entry transfers on any cycle where evt_valid and
  // evt_ready are both high; evt_valid never depends on evt_ready.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign evt_valid = !empty;
  assign evt_data  = mem[rd_ptr[AW-1:0]];
  assign push      = count_valid && (wrap_up || wrap_dn || jump || match);
  assign pop       = evt_valid && evt_ready;
  assign drop      = push && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev       <= 4'd0;
      prev_valid <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ovf        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'd0;
    end else begin
      if (count_valid) begin
        prev       <= count_in;
        prev_valid <= 1'b1;
      end
      // A push into a full FIFO still lands when the head leaves this cycle.
      if (push && !drop) begin
        mem[wr_ptr[AW-1:0]] <= {jump, wrap_dn, wrap_up, match, count_in};
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

`ifdef COUNT_WRAP_MONITOR_STATS_EN
  logic [CNT_W-1:0] up_q, dn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      up_q <= '0;
      dn_q <= '0;
    end else if (count_valid) begin
      if (wrap_up && (up_q != {CNT_W{1'b1}})) up_q <= up_q + 1'b1;
      if (wrap_dn && (dn_q != {CNT_W{1'b1}})) dn_q <= dn_q + 1'b1;
    end
  end

  assign wrap_up_cnt = up_q;
  assign wrap_dn_cnt = dn_q;
`else
  assign wrap_up_cnt = '0;
  assign wrap_dn_cnt = '0;
`endif

endmodule
